// File: rtl/execute_muldiv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | execute_muldiv_ctrl_pkg                                              |
// | RV32M operation encoding and shared constants for the mul/div unit.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package execute_muldiv_ctrl_pkg;

    localparam int MULDIV_CYCLES = 32;

    // Encodings are the instruction's funct3 field.
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op[2] & op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_muldiv_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | execute_muldiv_ctrl_if                                               |
// | Execute-stage <-> mul/div sequencer handshake and operand bus.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface execute_muldiv_ctrl_if
    import execute_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            start;
    muldiv_op_t      op;
    logic            flush;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, flush, data1, data2,
        input  stall, done, result
    );

    modport slave (
        input  start, op, flush, data1, data2,
        output stall, done, result
    );
endinterface
`default_nettype wire

// File: rtl/execute_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | execute_muldiv_ctrl                                                  |
// | Iterative RV32M shift-add multiplier / restoring divider sequencer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module execute_muldiv_ctrl
    import execute_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input wire clk,
    input wire rst,
    execute_muldiv_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(MULDIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q,   state_d;
    muldiv_op_t        op_q,      op_d;
    logic [XLEN-1:0]   data1_q,   data1_d;
    logic [XLEN-1:0]   data2_q,   data2_d;
    logic [2*XLEN-1:0] acc_q,     acc_d;
    logic [XLEN-1:0]   opb_q,     opb_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q,  result_d;
    logic              done_q,    done_d;

    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [XLEN:0]     rem_shift;
    logic [XLEN-1:0]   rem_diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    // Operand signedness and magnitudes from the latched operation.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (op_q)
            MULH, DIV, REM: begin
                sign_a = data1_q[XLEN-1];
                sign_b = data2_q[XLEN-1];
            end
            MULHSU:  sign_a = data1_q[XLEN-1];
            default: ;
        endcase
        mag_a = sign_a ? -data1_q : data1_q;
        mag_b = sign_b ? -data2_q : data2_q;
    end

    // One iteration of each algorithm on the shared accumulator.
    // The shifted partial remainder needs XLEN+1 bits for divisors above 2^(XLEN-1).
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        rem_shift = acc_q[2*XLEN-1:XLEN-1];
        rem_ge    = (rem_shift >= {1'b0, opb_q});
        rem_diff  = rem_shift[XLEN-1:0] - opb_q;
        div_next  = {(rem_ge ? rem_diff : rem_shift[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
        prod      = neg_res_q ? -acc_q : acc_q;
        quot      = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem       = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d    = bus.op;
                    data1_d = bus.data1;
                    data2_d = bus.data2;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                neg_res_d = sign_a ^ sign_b;
                neg_rem_d = sign_a;
                acc_d     = {{XLEN{1'b0}}, mag_a};
                opb_d     = mag_b;
                cnt_d     = '0;
                if (is_div(op_q) && data2_q == '0) begin
                    result_d = is_rem(op_q) ? data1_q : '1;
                    state_d  = S_DONE;
                end else if ((op_q == DIV || op_q == REM) &&
                             data1_q == INT_MIN && data2_q == '1) begin
                    result_d = (op_q == REM) ? '0 : INT_MIN;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                case (op_q)
                    MUL:                 result_d = prod[XLEN-1:0];
                    MULH, MULHSU, MULHU: result_d = prod[2*XLEN-1:XLEN];
                    DIV, DIVU:           result_d = quot;
                    default:             result_d = rem;
                endcase
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A flush discards the in-flight op; once DONE is reached the result is committed.
        if (bus.flush && state_q != S_DONE) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= MUL;
            data1_q   <= '0;
            data2_q   <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign bus.stall  = bus.start & (state_q != S_DONE) & ~bus.flush;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_execute_muldiv_ctrl                                               |
// | Directed-vector self-checking bench for the RV32M mul/div sequencer. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_execute_muldiv_ctrl;
    import execute_muldiv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    execute_muldiv_ctrl_if #(.XLEN(32)) mif ();

    execute_muldiv_ctrl #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one op at cycle 0, scrambles the input bus afterwards, and checks
    // the done cycle, the stall profile, the result and the single-cycle done pulse.
    task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
        int cyc       = 0;
        int stall_bad = 0;
        bit seen      = 1'b0;
        @(posedge clk); #1;
        mif.start = 1'b1;
        mif.op    = o;
        mif.data1 = a;
        mif.data2 = b;
        while (!seen && cyc <= 50) begin
            @(negedge clk);
            if (mif.stall !== (cyc < exp_cyc)) stall_bad++;
            if (mif.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (cyc == 0) begin
                    mif.data1 = ~a;
                    mif.data2 = a ^ b ^ 32'h5;
                    mif.op    = muldiv_op_t'(o ^ 3'b010);
                end
                cyc++;
            end
        end
        check_val({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check_val({tag, " result"}, mif.result, exp_res);
        check_val({tag, " stall_profile"}, 32'(stall_bad), 32'd0);
        @(posedge clk); #1;
        mif.start = 1'b0;
        @(negedge clk);
        check_val({tag, " done_width"}, 32'(mif.done), 32'd0);
    endtask

    initial begin
        int  cnt;
        bit  done_seen;

        mif.start = 1'b0;
        mif.op    = MUL;
        mif.flush = 1'b0;
        mif.data1 = '0;
        mif.data2 = '0;

        repeat (2) @(negedge clk);
        check_val("reset done", 32'(mif.done), 32'd0);
        check_val("reset result", mif.result, 32'd0);
        check_val("reset stall_idle", 32'(mif.stall), 32'd0);
        mif.start = 1'b1;
        #1;
        check_val("reset stall_start", 32'(mif.stall), 32'd1);
        mif.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        run_op("mul",      MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("div_by0",  DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 2);
        run_op("rem_by0",  REM,    32'd5,          32'd0,         32'd5,         2);
        run_op("div_ovf",  DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("rem_ovf",  REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2);
        run_op("mulh",     MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35);
        run_op("mulhu",    MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        run_op("mulhsu",   MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);

        // Reset asserted in CALC cycle 10 with start held high.
        @(posedge clk); #1;
        mif.start = 1'b1;
        mif.op    = MULHU;
        mif.data1 = 32'hFFFF_FFFF;
        mif.data2 = 32'hFFFF_FFFF;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("midrst done", 32'(mif.done), 32'd0);
        check_val("midrst result", mif.result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        while (mif.done !== 1'b1 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check_val("midrst done_cycle", 32'(cnt), 32'd35);
        check_val("midrst result_after", mif.result, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        mif.start = 1'b0;

        run_op("div",      DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35);
        run_op("rem",      REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35);
        run_op("divu",     DIVU,   32'd100,        32'd7,         32'd14,        35);
        run_op("remu",     REMU,   32'd100,        32'd7,         32'd2,         35);
        run_op("divu_big", DIVU,   32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1,         35);
        run_op("remu_big", REMU,   32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1,         35);

        // Flush in cycle 20 of a DIV; the previous result (1) must survive.
        @(posedge clk); #1;
        mif.start = 1'b1;
        mif.op    = DIV;
        mif.data1 = 32'd1000;
        mif.data2 = 32'd3;
        repeat (20) @(posedge clk);
        #1;
        mif.flush = 1'b1;
        @(negedge clk);
        check_val("flush stall", 32'(mif.stall), 32'd0);
        @(posedge clk); #1;
        mif.flush = 1'b0;
        mif.start = 1'b0;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (mif.done === 1'b1) done_seen = 1'b1;
        end
        check_val("flush no_done", 32'(done_seen), 32'd0);
        check_val("flush result_kept", mif.result, 32'd1);
        run_op("divu_after_flush", DIVU, 32'd9, 32'd3, 32'd3, 35);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_muldiv_ctrl.md
# execute_muldiv_ctrl

Iterative RV32M multiply/divide sequencer attached to the execute stage. It accepts an M-extension operation from the execute stage and latches the operands. It runs a shift-add multiply or restoring divide, one bit per cycle, and holds the pipeline stalled until the result is ready. It handles RISC-V divide-by-zero and signed-overflow cases with a short-circuit path.

## Interface
- `XLEN`, 32: operand/result width (only 32 supported).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  execute stage holds an M-op; level, held until `done`.
- `op`  in  3  funct3 (`muldiv_op_t`): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `flush`  in  1  synchronous abort (branch/exception flush).
- `data1`  in  32  rs1 value.
- `data2`  in  32  rs2 value.
- `stall`  out  1  freeze IF/ID/EX; combinational.
- `done`  out  1  one-cycle result-valid pulse; registered.
- `result`  out  32  result; registered, held until next `done`.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - `start`=1 and `flush`=0: latch `op`, `data1`, `data2`, then go to PREP.
  - Later changes on `data1`, `data2` or `op` are ignored until IDLE is re-entered.
- PREP:
  - Compute operand magnitudes. Signed operands are DIV/REM both, MULH both, MULHSU rs1 only.
  - Record result sign.
  - Divisor == 0 → DONE. Quotient ops (DIV, DIVU) return 0xFFFFFFFF; remainder ops (REM, REMU) return the dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF → DONE. DIV returns 0x80000000; REM returns 0.
  - Otherwise clear the 5-bit counter and go to CALC.
- CALC, 32 cycles:
  - Multiply: 64-bit accumulator shift-add on multiplier LSB.
  - Divide: restoring step, shift remainder:quotient left by 1, subtract divisor if no borrow.
  - Counter == 31 → FIX.
- FIX:
  - Negate the 64-bit product or the quotient/remainder if the recorded sign says so.
  - The remainder takes the dividend's sign.
  - Select low word (MUL) or high word (MULH*), quotient or remainder, into `result`.
  - Go to DONE.
- DONE: `done`=1 for exactly this cycle, then IDLE.
- Outputs:
  - `stall` = `start` & (state != DONE) & ~`flush`.
  - `result` updates only on entry to DONE.
- `flush`:
  - Any state except DONE → IDLE next edge; no `done`, `result` unchanged.
  - `flush` in DONE has no effect; `done` is already issued.
- Reset (`rst`=0, any time):
  - State IDLE; counter, accumulators, `result` = 0; `done` = 0.
  - `stall` follows its equation; it is 0 if `start`=0.
- No back-to-back restart: `start` is still high in the DONE cycle but is only sampled in IDLE. The next instruction's `start` is seen the following cycle.

## Timing
- Cycle 0 is the IDLE cycle with `start`=1.
- Normal path:
  - PREP at cycle 1, CALC cycles 2–33, FIX cycle 34, DONE cycle 35.
  - `stall`=1 for cycles 0–34; `stall`=0 and `done`=1 in cycle 35, and the pipeline advances at the end of cycle 35.
- Short-circuit (div-by-zero, overflow): DONE at cycle 2; `stall`=1 in cycles 0–1.
- Flush asserted in cycle k ≥ 1: `stall`=0 in cycle k; IDLE at k+1.
- `result` is valid from the DONE cycle until the next DONE.

## Structure
- In `common`:
  - `muldiv_op_t` enum, 3 bits, matching funct3: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - `MULDIV_CYCLES` = 32.
- State enum stays local to the module.
- Single module; no sub-module. The accumulator datapath is shared between multiply and divide and is controlled directly by the FSM.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result`=0xFFFFFFEB, `done` in cycle 35, `stall` high cycles 0–34 then low.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide 5 by 0:
  - DIV → 0xFFFFFFFF and REM → 5, `done` in cycle 2.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, `done` in cycle 2.
- `rst`=0 during CALC cycle 10:
  - `done`=0 and `result`=0 immediately.
  - With `start` held, the op restarts after release and `done` arrives 35 cycles later with the correct value.
- `flush`=1 in cycle 20:
  - `stall`=0 that cycle, IDLE next cycle, no `done` pulse, previous `result` unchanged.
  - A new DIVU 9/3 issued afterwards returns 3.
